uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 200000, giving the maximum clk cycles to wait for tx_done per byte.
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-004 The block SHALL have port req, input, 4, per-requester send request; held by the requester until its gnt pulse.
REQ-005 The block SHALL have port data_in, input, 32, packed request bytes; requester i uses data_in[8i+7:8i].
REQ-006 The block SHALL have port gnt, output, 4, a one-hot, one-cycle completion acknowledge.
REQ-007 The block SHALL have port tx_data, output, 8, the byte driven to the transmitter's data input.
REQ-008 The block SHALL have port tx_start, output, 1, the start strobe to the transmitter.
REQ-009 The block SHALL have port tx_done, input, 1, the transmitter completion flag, which is high for one or more cycles.
REQ-010 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-011 The block SHALL have port grant_id, output, 2, the index of the current or last served requester.
REQ-012 The block SHALL have port timeout_err, output, 1, a sticky watchdog error flag.

Function
REQ-013 The FSM SHALL have states IDLE, START, WAIT_DONE and RELEASE, one-hot encoded.
REQ-014 In IDLE, when req is non-zero and tx_done=0, the block SHALL select the winner by round-robin and move to START at the next edge.
- Search order: last+1, last+2, last+3, last (mod 4).
- The winner's byte is registered into tx_data and its index into grant_id.
REQ-015 When req is non-zero but tx_done=1, the block SHALL stay in IDLE.
REQ-016 In START, tx_start SHALL be high for exactly one cycle, and the FSM SHALL then move to WAIT_DONE.
REQ-017 In WAIT_DONE, the FSM SHALL move to RELEASE on the first cycle where tx_done=1 and the registered previous tx_done=0.
REQ-018 tx_data SHALL stay stable from START until the FSM leaves RELEASE.
REQ-019 In RELEASE, gnt[grant_id] SHALL be high for one cycle, last SHALL be set to grant_id, and the FSM SHALL return to IDLE.
REQ-020 Latency SHALL be fixed: req sampled in IDLE at edge N gives tx_start high in cycle N+1.
REQ-021 Latency SHALL be fixed: a tx_done rising edge sampled at edge M gives gnt high in cycle M+1.
REQ-022 Changes to req or data_in after selection SHALL be ignored until RELEASE; the transfer always completes.
REQ-023 Simultaneous requests SHALL be served in round-robin order with no requester starved.
- Each pending requester is served within 4 transfers.
REQ-024 A requester still asserting req in the cycle after its gnt SHALL be treated as a new request.

Reset
REQ-025 When rst=1 at a clk edge, the block SHALL set:
- state to IDLE;
- gnt=0, tx_start=0, tx_data=0, busy=0, grant_id=0;
- last=3, so requester 0 wins first;
- timeout_err=0 and the watchdog counter to 0.
REQ-026 Reset mid-transfer SHALL abort without issuing gnt; after reset, the block SHALL not start until tx_done is low.

Configuration
REQ-027 With macro UART_ARB_TIMEOUT_EN defined, a counter SHALL clear on entry to WAIT_DONE and increment every WAIT_DONE cycle.
- On reaching TIMEOUT_CYCLES-1 without a tx_done edge, the FSM goes to RELEASE.
- The pending gnt is issued normally.
- timeout_err is set and held until rst.
REQ-028 Without UART_ARB_TIMEOUT_EN, the block SHALL:
- omit the counter;
- tie timeout_err to 0;
- wait in WAIT_DONE indefinitely;
- ignore TIMEOUT_CYCLES.

Verification
REQ-029 The bench SHALL drive req=0001, data_in[7:0]=8'hA5 and tx_done high 20 cycles after tx_start, and SHALL check: one tx_start pulse, tx_data=8'hA5, gnt=0001 for one cycle, grant_id=0.
REQ-030 The bench SHALL hold req=1111 with distinct bytes 8'h11/22/33/44 and SHALL check grant order 0,1,2,3,0 with one tx_start per grant.
REQ-031 The bench SHALL hold req=1010 from reset and SHALL check grants alternate 1,3,1,3 and that requesters 0 and 2 are never granted.
REQ-032 The bench SHALL drop req[2] one cycle after its tx_start and SHALL check that the transfer still completes and gnt=0100 is issued.
REQ-033 The bench SHALL assert rst for one cycle in WAIT_DONE and SHALL check that no gnt is issued, all outputs take reset values, and the next grant goes to requester 0.
REQ-034 With UART_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=50, the bench SHALL never assert tx_done and SHALL check that gnt is issued 50 cycles after WAIT_DONE entry and that timeout_err=1 stays high until rst.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one UART transmitter among four byte requesters.
// Optional tx_done watchdog is enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 200000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [31:0] data_in,
    output logic [3:0]  gnt,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_done,
    output logic        busy,
    output logic [1:0]  grant_id,
    output logic        timeout_err
);
    typedef enum logic [3:0] {
        IDLE      = 4'b0001,
        START     = 4'b0010,
        WAIT_DONE = 4'b0100,
        RELEASE   = 4'b1000
    } state_t;

    state_t     state, state_nx;
    logic [1:0] last, win;
    logic       found, done_q, done_rise, expired;

    assign done_rise = tx_done & ~done_q;
    assign tx_start  = state == START;
    assign busy      = state != IDLE;
    assign gnt       = state == RELEASE ? 4'b0001 << grant_id : 4'b0000;

    // Search starts just after the last served requester and wraps back to it.
    always_comb begin
        win   = last;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (!found && req[last + 2'(k)]) begin
                win   = last + 2'(k);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state == IDLE      ? ((|req && !tx_done) ? START : IDLE) :
                   state == START     ? WAIT_DONE :
                   state == WAIT_DONE ? ((done_rise || expired) ? RELEASE : WAIT_DONE) :
                                        IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tx_data  <= 8'h00;
            grant_id <= 2'd0;
            last     <= 2'd3;
            done_q   <= 1'b0;
        end else begin
            state  <= state_nx;
            done_q <= tx_done;
            if (state == IDLE && state_nx == START) begin
                tx_data  <= data_in[{win, 3'b000} +: 8];
                grant_id <= win;
            end
            if (state == RELEASE) last <= grant_id;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;

    assign expired = state == WAIT_DONE && cnt == CW'(TIMEOUT_CYCLES - 1);

    // Counter is held at zero outside WAIT_DONE, so it is clear on every entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            timeout_err <= 1'b0;
        end else begin
            cnt <= state == WAIT_DONE ? cnt + 1'b1 : '0;
            if (expired && !done_rise) timeout_err <= 1'b1;
        end
    end
`else
    assign expired     = 1'b0;
    assign timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and randomized checks of uart_tx_arbiter against a round-robin model.
module tb_uart_tx_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = 4'b0;
    logic [31:0] data_in = 32'h0;
    logic        tx_done = 1'b0;
    logic [3:0]  gnt;
    logic [7:0]  tx_data;
    logic        tx_start, busy, timeout_err;
    logic [1:0]  grant_id;

    int          checks = 0;
    int          errors = 0;
    int          ref_last = 3;
    logic [3:0]  gnt_seen = 4'b0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.TIMEOUT_CYCLES(50)) dut (
        .clk(clk), .rst(rst), .req(req), .data_in(data_in), .gnt(gnt),
        .tx_data(tx_data), .tx_start(tx_start), .tx_done(tx_done),
        .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int rr(input logic [3:0] r, input int lst);
        for (int k = 1; k <= 4; k++)
            if (r[(lst + k) % 4]) return (lst + k) % 4;
        return -1;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ref_last = 3;
    endtask

    // Entered at an IDLE negedge with req already driven; returns at the IDLE negedge after gnt.
    task automatic xfer(input int id, input logic [7:0] b, input int dly, input int hold,
                        input bit mutate, input bit drop, input bit rel);
        int   starts;
        logic bad;
        bad = 1'b0;
        @(negedge clk);
        starts = int'(tx_start);
        gnt_seen |= gnt;
        chk("tx_start", 32'(tx_start), 32'd1);
        chk("grant_id", 32'(grant_id), 32'(id));
        chk("tx_data_start", 32'(tx_data), 32'(b));
        if (mutate) begin
            data_in = $urandom;
            req = req ^ (4'($urandom) & ~(4'b1 << id));
        end
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            if (drop && i == 0) req[id] = 1'b0;
            starts += int'(tx_start);
            gnt_seen |= gnt;
            if (gnt != 4'b0 || tx_data != b || !busy) bad = 1'b1;
        end
        chk("wait_stable", 32'(bad), 32'd0);
        tx_done = 1'b1;
        @(negedge clk);
        starts += int'(tx_start);
        gnt_seen |= gnt;
        chk("gnt", 32'(gnt), 32'(4'b1 << id));
        chk("tx_data_release", 32'(tx_data), 32'(b));
        if (rel) req[id] = 1'b0;
        if (hold == 1) tx_done = 1'b0;
        @(negedge clk);
        tx_done = 1'b0;
        starts += int'(tx_start);
        gnt_seen |= gnt;
        chk("gnt_one_cycle", 32'(gnt), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("start_count", 32'(starts), 32'd1);
    endtask

    initial begin
        logic [3:0] r;
        logic [7:0] bb;
        logic       bad;
        int         w;

        do_reset();
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);

        req = 4'b0001;
        data_in = 32'h000000A5;
        xfer(0, 8'hA5, 20, 1, 1'b0, 1'b0, 1'b1);
        ref_last = 0;
        @(negedge clk);
        chk("idle_no_req", 32'(busy), 32'd0);

        req = 4'hF;
        data_in = 32'h87654321;
        @(negedge clk);
        chk("rr_before_rst", 32'(grant_id), 32'd1);
        chk("start_before_rst", 32'(tx_start), 32'd1);
        repeat (3) @(negedge clk);
        tx_done = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_gnt", 32'(gnt), 32'd0);
        chk("mid_rst_tx_start", 32'(tx_start), 32'd0);
        chk("mid_rst_tx_data", 32'(tx_data), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_grant_id", 32'(grant_id), 32'd0);
        chk("mid_rst_timeout_err", 32'(timeout_err), 32'd0);
        bad = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (busy || gnt != 4'b0 || tx_start) bad = 1'b1;
        end
        chk("hold_while_tx_done", 32'(bad), 32'd0);
        tx_done = 1'b0;
        ref_last = 3;
        xfer(0, 8'h21, 4, 1, 1'b0, 1'b0, 1'b1);
        ref_last = 0;

        do_reset();
        req = 4'hF;
        data_in = 32'h44332211;
        for (int i = 0; i < 5; i++) begin
            w = i % 4;
            bb = 8'(17 * (w + 1));
            xfer(w, bb, 3 + i, 1, 1'b0, 1'b0, 1'b0);
            ref_last = w;
        end

        do_reset();
        req = 4'b1010;
        data_in = 32'hDEADBEEF;
        gnt_seen = 4'b0;
        xfer(1, 8'hBE, 2, 2, 1'b0, 1'b0, 1'b0);
        xfer(3, 8'hDE, 5, 1, 1'b0, 1'b0, 1'b0);
        xfer(1, 8'hBE, 1, 1, 1'b0, 1'b0, 1'b0);
        xfer(3, 8'hDE, 7, 2, 1'b0, 1'b0, 1'b0);
        chk("never_0_or_2", 32'(gnt_seen & 4'b0101), 32'd0);
        ref_last = 3;

        req = 4'b0100;
        data_in = 32'h00C30000;
        xfer(2, 8'hC3, 6, 1, 1'b0, 1'b1, 1'b0);
        ref_last = 2;
        @(negedge clk);
        chk("idle_after_drop", 32'(busy), 32'd0);

        for (int n = 0; n < 30; n++) begin
            r = 4'($urandom);
            req = r;
            if (r == 4'b0) begin
                @(negedge clk);
                chk("rand_idle_busy", 32'(busy), 32'd0);
                chk("rand_idle_start", 32'(tx_start), 32'd0);
            end else begin
                data_in = $urandom;
                w = rr(r, ref_last);
                bb = data_in[8 * w +: 8];
                xfer(w, bb, $urandom_range(1, 20), $urandom_range(1, 2),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
                ref_last = w;
            end
        end

        do_reset();
        req = 4'b0001;
        data_in = 32'h0000005A;
`ifdef UART_ARB_TIMEOUT_EN
        @(negedge clk);
        chk("to_start", 32'(tx_start), 32'd1);
        chk("to_err_before", 32'(timeout_err), 32'd0);
        bad = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (gnt != 4'b0 || timeout_err) bad = 1'b1;
        end
        chk("to_early", 32'(bad), 32'd0);
        @(negedge clk);
        chk("to_gnt", 32'(gnt), 32'd1);
        chk("to_err_set", 32'(timeout_err), 32'd1);
        req = 4'b0;
        @(negedge clk);
        chk("to_gnt_one_cycle", 32'(gnt), 32'd0);
        req = 4'b0010;
        xfer(1, 8'h00, 3, 1, 1'b0, 1'b0, 1'b1);
        chk("to_err_sticky", 32'(timeout_err), 32'd1);
        do_reset();
        chk("to_err_cleared", 32'(timeout_err), 32'd0);
`else
        xfer(0, 8'h5A, 80, 1, 1'b0, 1'b0, 1'b1);
        chk("no_timeout_err", 32'(timeout_err), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
